// File: rtl/instr_fetch.sv
// instr_fetch: PC + one-outstanding imem request (req/rsp) -> registered instr/instr_pc to decoder (valid/ready), redirect squashes wrong path
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_fetch_pc, w_fetch_pc, r_instr, w_instr, r_instr_pc, w_instr_pc;
  logic        r_drop, w_drop;
  logic [31:0] w_redir;
  assign w_redir = {redirect_pc[31:2], 2'b00};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_instr    <= 32'h0000_0013;
      r_instr_pc <= 32'h0;
    end else begin
      r_state    <= w_state;
      r_fetch_pc <= w_fetch_pc;
      r_drop     <= w_drop;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
    end
  always_comb begin
    w_state    = r_state;
    w_fetch_pc = redirect_valid ? w_redir : r_fetch_pc;
    w_drop     = r_drop;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    case (r_state)
      IDLE: w_state = REQ;
      REQ: if (imem_req_ready) begin
        w_state = WAIT;
        w_drop  = redirect_valid;
      end
      WAIT: if (imem_rsp_valid) begin
        w_drop = 1'b0;
        if (redirect_valid || r_drop) w_state = REQ;
        else begin
          w_instr    = imem_rsp_data;
          w_instr_pc = r_fetch_pc;
          w_state    = HOLD;
        end
      end else if (redirect_valid) w_drop = 1'b1;
      HOLD: if (redirect_valid || instr_ready) begin
        w_state    = REQ;
        w_fetch_pc = redirect_valid ? w_redir : r_fetch_pc + 32'd4;
      end
      default: w_state = IDLE;
    endcase
  end
  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = (r_state == HOLD);
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench; two DUTs share stimulus, dut_a (RESET_PC 0x100) and dut_b (RESET_PC 0xFFFFFFFC)
module tb_instr_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0, reset = 1'b1;
  logic req_ready = 1'b0, rsp_valid = 1'b0, red_valid = 1'b0, irdy = 1'b0;
  logic [31:0] rsp_data = '0, red_pc = '0;
  logic reqv_a, iv_a, reqv_b, iv_b;
  logic [31:0] addr_a, instr_a, ipc_a, addr_b, instr_b, ipc_b, held;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(32'h0000_0100)) dut_a (
    .clk(clk), .reset(reset), .imem_req_valid(reqv_a), .imem_req_ready(req_ready), .imem_req_addr(addr_a),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .redirect_valid(red_valid), .redirect_pc(red_pc),
    .instr_valid(iv_a), .instr_ready(irdy), .instr(instr_a), .instr_pc(ipc_a));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .imem_req_valid(reqv_b), .imem_req_ready(req_ready), .imem_req_addr(addr_b),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .redirect_valid(red_valid), .redirect_pc(red_pc),
    .instr_valid(iv_b), .instr_ready(irdy), .instr(instr_b), .instr_pc(ipc_b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    tick();
    checks++; if (reqv_a !== 1'b0) begin errors++; $display("FAIL rst_reqv got %b exp 0", reqv_a); end
    checks++; if (iv_a !== 1'b0) begin errors++; $display("FAIL rst_iv got %b exp 0", iv_a); end
    checks++; if (addr_a !== 32'h100) begin errors++; $display("FAIL rst_addr_a got %h exp 00000100", addr_a); end
    checks++; if (instr_a !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr_a); end
    checks++; if (ipc_a !== 32'h0) begin errors++; $display("FAIL rst_ipc got %h exp 0", ipc_a); end
    checks++; if (addr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr_b got %h exp fffffffc", addr_b); end
    reset = 1'b0;
    checks++; if (reqv_a !== 1'b0) begin errors++; $display("FAIL idle_reqv got %b exp 0", reqv_a); end
    tick();
    checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h100) begin errors++; $display("FAIL first_req got v=%b a=%h exp v=1 a=00000100", reqv_a, addr_a); end
  endtask
  task automatic test_throughput();
    req_ready = 1'b1;
    irdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL tp_req%0d got v=%b a=%h exp v=1 a=%h", k, reqv_a, addr_a, 32'h100 + 32'(4 * k)); end
      tick();
      rsp_valid = 1'b1;
      rsp_data = (32'h100 + 32'(4 * k)) ^ K;
      checks++; if (reqv_a !== 1'b0 || iv_a !== 1'b0) begin errors++; $display("FAIL tp_wait%0d got reqv=%b iv=%b exp 0 0", k, reqv_a, iv_a); end
      tick();
      rsp_valid = 1'b0;
      checks++; if (iv_a !== 1'b1 || ipc_a !== 32'h100 + 32'(4 * k) || instr_a !== ((32'h100 + 32'(4 * k)) ^ K)) begin errors++; $display("FAIL tp_instr%0d got iv=%b pc=%h i=%h", k, iv_a, ipc_a, instr_a); end
      tick();
    end
    irdy = 1'b0;
  endtask
  task automatic test_stall();
    checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h10C) begin errors++; $display("FAIL st_req got v=%b a=%h exp v=1 a=0000010c", reqv_a, addr_a); end
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h10C ^ K;
    tick();
    rsp_valid = 1'b0;
    held = 32'h10C ^ K;
    for (int c = 0; c < 5; c++) begin
      checks++; if (iv_a !== 1'b1 || instr_a !== held || ipc_a !== 32'h10C || reqv_a !== 1'b0 || addr_a !== 32'h10C) begin errors++; $display("FAIL stall%0d got iv=%b i=%h pc=%h reqv=%b a=%h", c, iv_a, instr_a, ipc_a, reqv_a, addr_a); end
      tick();
    end
    checks++; if (iv_a !== 1'b1 || addr_a !== 32'h10C) begin errors++; $display("FAIL stall_end got iv=%b a=%h exp iv=1 a=0000010c", iv_a, addr_a); end
    irdy = 1'b1;
    tick();
    irdy = 1'b0;
    checks++; if (iv_a !== 1'b0 || reqv_a !== 1'b1 || addr_a !== 32'h110) begin errors++; $display("FAIL st_adv got iv=%b reqv=%b a=%h exp 0 1 00000110", iv_a, reqv_a, addr_a); end
  endtask
  task automatic test_redirect_wait();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    red_valid = 1'b1;
    red_pc = 32'h200;
    tick();
    red_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (iv_a !== 1'b0 || reqv_a !== 1'b0 || addr_a !== 32'h200) begin errors++; $display("FAIL rw_wait%0d got iv=%b reqv=%b a=%h", c, iv_a, reqv_a, addr_a); end
      if (c < 2) tick();
    end
    rsp_valid = 1'b1;
    rsp_data = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    checks++; if (iv_a !== 1'b0 || reqv_a !== 1'b1 || addr_a !== 32'h200) begin errors++; $display("FAIL rw_req got iv=%b reqv=%b a=%h exp 0 1 00000200", iv_a, reqv_a, addr_a); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h200 ^ K;
    tick();
    rsp_valid = 1'b0;
    checks++; if (iv_a !== 1'b1 || ipc_a !== 32'h200 || instr_a !== (32'h200 ^ K)) begin errors++; $display("FAIL rw_deliver got iv=%b pc=%h i=%h exp 1 00000200 a5a50200", iv_a, ipc_a, instr_a); end
  endtask
  task automatic test_redirect_hold();
    red_valid = 1'b1;
    red_pc = 32'h303;
    irdy = 1'b1;
    tick();
    red_valid = 1'b0;
    irdy = 1'b0;
    checks++; if (iv_a !== 1'b0 || reqv_a !== 1'b1 || addr_a !== 32'h300) begin errors++; $display("FAIL rh got iv=%b reqv=%b a=%h exp 0 1 00000300", iv_a, reqv_a, addr_a); end
  endtask
  task automatic test_req_stall_redirect();
    tick();
    checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h300) begin errors++; $display("FAIL rs_c1 got v=%b a=%h exp 1 00000300", reqv_a, addr_a); end
    red_valid = 1'b1;
    red_pc = 32'h40;
    tick();
    red_valid = 1'b0;
    checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h40) begin errors++; $display("FAIL rs_c2 got v=%b a=%h exp 1 00000040", reqv_a, addr_a); end
    tick();
    checks++; if (reqv_a !== 1'b1 || addr_a !== 32'h40) begin errors++; $display("FAIL rs_c3 got v=%b a=%h exp 1 00000040", reqv_a, addr_a); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++; if (reqv_a !== 1'b0) begin errors++; $display("FAIL rs_acc got v=%b exp 0", reqv_a); end
    rsp_valid = 1'b1;
    rsp_data = 32'h40 ^ K;
    tick();
    rsp_valid = 1'b0;
    checks++; if (iv_a !== 1'b1 || ipc_a !== 32'h40 || instr_a !== (32'h40 ^ K)) begin errors++; $display("FAIL rs_deliver got iv=%b pc=%h i=%h exp 1 00000040 a5a50040", iv_a, ipc_a, instr_a); end
    irdy = 1'b1;
    tick();
    irdy = 1'b0;
  endtask
  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (reqv_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req0 got v=%b a=%h exp 1 fffffffc", reqv_b, addr_b); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    checks++; if (iv_b !== 1'b1 || ipc_b !== 32'hFFFF_FFFC || instr_b !== 32'h1234_5678) begin errors++; $display("FAIL wr_deliver got iv=%b pc=%h i=%h", iv_b, ipc_b, instr_b); end
    irdy = 1'b1;
    tick();
    irdy = 1'b0;
    checks++; if (reqv_b !== 1'b1 || addr_b !== 32'h0) begin errors++; $display("FAIL wr_wrap got v=%b a=%h exp 1 00000000", reqv_b, addr_b); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (reqv_b !== 1'b0 || iv_b !== 1'b0 || addr_b !== 32'hFFFF_FFFC || instr_b !== 32'h13 || ipc_b !== 32'h0) begin errors++; $display("FAIL wr_midrst got reqv=%b iv=%b a=%h i=%h pc=%h", reqv_b, iv_b, addr_b, instr_b, ipc_b); end
    tick();
    reset = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h0000_0BAD;
    tick();
    tick();
    rsp_valid = 1'b0;
    checks++; if (reqv_b !== 1'b1 || iv_b !== 1'b0 || addr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_stray got reqv=%b iv=%b a=%h exp 1 0 fffffffc", reqv_b, iv_b, addr_b); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h5555_AAAA;
    tick();
    rsp_valid = 1'b0;
    checks++; if (iv_b !== 1'b1 || ipc_b !== 32'hFFFF_FFFC || instr_b !== 32'h5555_AAAA) begin errors++; $display("FAIL wr_refetch got iv=%b pc=%h i=%h", iv_b, ipc_b, instr_b); end
  endtask
  initial begin
    test_reset();
    test_throughput();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_req_stall_redirect();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
